dual_sram: RTL and testbench
============================

// Module: dual_sram
// PURPOSE
//  True dual-port synchronous SRAM: two independent read/write ports (A, B) share one
//  DEPTH x WIDTH storage array on a single clock. Generic on-chip scratch/buffer memory
//  between two agents. Per-port mode select: read_ena=1 reads, read_ena=0 writes.
// PARAMETERS
//  WIDTH       8                 data word width in bits
//  DEPTH       8                 number of words
//  ADDR_WIDTH  $clog2(DEPTH)     address width (derived; do not override independently)
// PORTS
//  clk         in   1            single clock, all logic on rising edge
//  reset       in   1            synchronous, active-low reset
//  chip_sel    in   1            1 = array enabled for both ports; 0 = no access on either port
//  read_ena_a  in   1            port A mode: 1 = read, 0 = write
//  address_a   in   ADDR_WIDTH   port A word address
//  data_in_a   in   WIDTH        port A write data
//  data_out_a  out  WIDTH        port A registered read data
//  read_ena_b  in   1            port B mode: 1 = read, 0 = write
//  address_b   in   ADDR_WIDTH   port B word address
//  data_in_b   in   WIDTH        port B write data
//  data_out_b  out  WIDTH        port B registered read data
// BEHAVIOUR
//  - Reset (reset==0 at a rising clk edge): every memory word <= 0, data_out_a/b <= 0.
//    Reset overrides chip_sel and all port activity in that cycle; mid-operation reset
//    discards any write in that cycle.
//  - Write (chip_sel=1, read_ena_x=0): mem[address_x] <= data_in_x at the rising edge.
//    data_out_x holds its previous value during a write cycle.
//  - Read (chip_sel=1, read_ena_x=1): data_out_x <= mem[address_x] at the rising edge;
//    1-cycle latency, value visible after the edge that sampled the address.
//  - Idle (chip_sel=0): no write, no read; both data_out hold last value.
//  - Ports are fully independent; both may read, both write, or mix, every cycle.
//  - Both ports read same address: both return the stored word.
//  - Both ports write same address same cycle: port A data is stored (A has priority).
//  - One port reads address X while other writes X same cycle: read returns OLD
//    contents (read-before-write), unless DUAL_SRAM_FWD_EN is defined.
//  - Same port cannot read and write in one cycle (mode bit is exclusive).
//  - Addresses >= DEPTH (non-power-of-2 DEPTH): writes ignored, reads return 0.
//  - Storage is a reg array; no combinational path from inputs to data_out.
// CONFIGURATION
//  DUAL_SRAM_FWD_EN defined: cross-port write-to-read forwarding. When port X reads
//   address N in the same cycle port Y writes N, data_out_x <= data_in_y (new data);
//   if both ports write N, the reading-side case cannot occur; A-priority still holds.
//  DUAL_SRAM_FWD_EN undefined: read-before-write; data_out_x <= old mem[N].
//  Everything else identical in both builds.
// TESTING
//  1. Reset low one edge, then read A@4, B@7 -> data_out_a=0x00, data_out_b=0x00.
//  2. A writes 0xAA@4, next cycle A reads @4 -> data_out_a=0xAA one edge later;
//     A writes 0x25@6, 0xFF@1, 0xDA@2, read each back -> 0x25, 0xFF, 0xDA.
//  3. B writes 0xAA@0, 0x25@7, 0xFF@3, 0xDA@5; B reads each -> same values; A reads
//     @0 -> 0xAA (shared array); chip_sel=0 during a B write 0x11@3 -> @3 stays 0xFF.
//  4. After test 3, reset low one edge -> every address reads 0x00 on both ports,
//     data_out_a/b = 0x00 immediately after the reset edge.
//  5. Same edge: A writes 0x5A@2, B writes 0xC3@2 -> later read @2 = 0x5A.
//  6. @6=0x25; same edge A writes 0x99@6 while B reads @6 -> data_out_b=0x25
//     (0x99 with DUAL_SRAM_FWD_EN); next B read @6 -> 0x99 in both builds.

Source files
------------

// File: rtl/dual_sram.sv
// dual_sram: true dual-port DEPTH x WIDTH synchronous SRAM, port A wins same-address writes.
// Define DUAL_SRAM_FWD_EN for cross-port write-to-read forwarding; default is read-before-write.
module dual_sram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chip_sel,
  input  logic                  read_ena_a,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [WIDTH-1:0]      data_in_a,
  output logic [WIDTH-1:0]      data_out_a,
  input  logic                  read_ena_b,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [WIDTH-1:0]      data_in_b,
  output logic [WIDTH-1:0]      data_out_b
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic             ok_a, ok_b, wr_a, wr_b;
  logic [WIDTH-1:0] rd_a, rd_b;
  always_comb begin
    ok_a = int'(address_a) < DEPTH;
    ok_b = int'(address_b) < DEPTH;
    wr_a = chip_sel & ~read_ena_a & ok_a;
    wr_b = chip_sel & ~read_ena_b & ok_b;
    rd_a = ok_a ? mem[address_a] : '0;
    rd_b = ok_b ? mem[address_b] : '0;
`ifdef DUAL_SRAM_FWD_EN
    rd_a = (ok_a && wr_b && address_b == address_a) ? data_in_b : rd_a;
    rd_b = (ok_b && wr_a && address_a == address_b) ? data_in_a : rd_b;
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      data_out_a <= '0;
      data_out_b <= '0;
    end else if (chip_sel) begin
      if (read_ena_a) data_out_a <= rd_a;
      if (read_ena_b) data_out_b <= rd_b;
      // A is assigned last so it overrides B on a same-address collision
      if (wr_b) mem[address_b] <= data_in_b;
      if (wr_a) mem[address_a] <= data_in_a;
    end
  end
endmodule

// File: tb/tb_dual_sram.sv
// tb_dual_sram: scoreboard bench for dual_sram, spec-level memory model vs DUT outputs.
module tb_dual_sram;
  logic       clk = 0, reset, chip_sel, read_ena_a, read_ena_b;
  logic [2:0] address_a, address_b;
  logic [7:0] data_in_a, data_in_b, data_out_a, data_out_b;
  logic [7:0] m [8];
  logic [7:0] oa = 0, ob = 0;
  logic [7:0] qa [$], qb [$];
  int         tests = 0, fails = 0;

  dual_sram dut (
    .clk(clk), .reset(reset), .chip_sel(chip_sel),
    .read_ena_a(read_ena_a), .address_a(address_a), .data_in_a(data_in_a), .data_out_a(data_out_a),
    .read_ena_b(read_ena_b), .address_b(address_b), .data_in_b(data_in_b), .data_out_b(data_out_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() != 0) chk("data_out_a", data_out_a, qa.pop_front());
    if (qb.size() != 0) chk("data_out_b", data_out_b, qb.pop_front());
  end

  task automatic step(input logic r, cs, ra, input logic [2:0] aa, input logic [7:0] da,
                      input logic rb, input logic [2:0] ab, input logic [7:0] db);
    reset = r; chip_sel = cs;
    read_ena_a = ra; address_a = aa; data_in_a = da;
    read_ena_b = rb; address_b = ab; data_in_b = db;
    @(posedge clk);
    if (!r) begin
      foreach (m[i]) m[i] = 0;
      oa = 0; ob = 0;
    end else if (cs) begin
      if (ra) oa = m[aa];
      if (rb) ob = m[ab];
`ifdef DUAL_SRAM_FWD_EN
      if (ra && !rb && aa == ab) oa = db;
      if (rb && !ra && aa == ab) ob = da;
`endif
      if (!rb) m[ab] = db;
      if (!ra) m[aa] = da;
    end
    qa.push_back(oa);
    qb.push_back(ob);
    #1;
  endtask

  initial begin
    logic [2:0] ad [4];
    logic [7:0] dv [4];
    step(0, 1, 1, 4, 0, 1, 7, 0);
    step(1, 1, 1, 4, 0, 1, 7, 0);
    ad = '{4, 6, 1, 2};
    dv = '{8'hAA, 8'h25, 8'hFF, 8'hDA};
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, ad[i], dv[i], 1, 0, 0);
      step(1, 1, 1, ad[i], 0, 1, 0, 0);
    end
    ad = '{0, 7, 3, 5};
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 0, ad[i], dv[i]);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 1, ad[i], 0);
    step(1, 1, 1, 0, 0, 1, 5, 0);
    step(1, 0, 1, 0, 0, 0, 3, 8'h11);
    step(1, 1, 1, 3, 0, 1, 3, 0);
    step(0, 1, 0, 1, 8'h77, 0, 2, 8'h66);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 3'(i), 0, 1, 3'(7 - i), 0);
    step(1, 1, 0, 2, 8'h5A, 0, 2, 8'hC3);
    step(1, 1, 1, 2, 0, 1, 2, 0);
    step(1, 1, 0, 6, 8'h25, 1, 0, 0);
    step(1, 1, 0, 6, 8'h99, 1, 6, 0);
    step(1, 1, 1, 0, 0, 1, 6, 0);
    step(1, 1, 0, 3, 8'h3C, 1, 3, 0);
    step(1, 1, 1, 3, 0, 1, 3, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) != 0, $urandom_range(0, 9) != 0,
           1'($urandom), 3'($urandom), 8'($urandom),
           1'($urandom), 3'($urandom), 8'($urandom));
    step(1, 0, 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL drain qa=%0d qb=%0d expected 0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
